// File: rtl/mac_pkg.sv
// Shared multiply-accumulate constants and types, common to the multiplier and accumulator.
package mac_pkg;

  localparam int unsigned MUL_IBITWIDTH   = 32;
  localparam int unsigned PROD_BITWIDTH   = 2 * MUL_IBITWIDTH;
  localparam int unsigned ACC_BITWIDTH    = 72;
  localparam int unsigned ACC_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ADD,
    ACC_DONE
  } acc_op_e;

  // Group counter width; a single-product group still needs one bit.
  function automatic int unsigned cnt_bits(input int unsigned len);
    return (len <= 1) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/accumulator_sat_add.sv
// Accumulator adder: OBITWIDTH + zero-extended IBITWIDTH operand.
// ACC_SAT_EN selects clamp-to-all-ones on carry-out; otherwise wraps and oSat is 0.
module accumulator_sat_add #(
  parameter int unsigned IBITWIDTH = 64,
  parameter int unsigned OBITWIDTH = 72
) (
  input  logic [OBITWIDTH-1:0] iA,
  input  logic [IBITWIDTH-1:0] iB,
  output logic [OBITWIDTH-1:0] oSum,
  output logic                 oSat
);

`ifdef ACC_SAT_EN
  logic [OBITWIDTH:0] w_full;

  assign w_full = {1'b0, iA} + (OBITWIDTH+1)'(iB);
  assign oSat   = w_full[OBITWIDTH];
  assign oSum   = w_full[OBITWIDTH] ? '1 : w_full[OBITWIDTH-1:0];
`else
  assign oSum = iA + OBITWIDTH'(iB);
  assign oSat = 1'b0;
`endif

endmodule

// File: rtl/accumulator_64b_reg_hs.sv
// Groups LEN accepted products into one sum held in a valid/ready output buffer.
// Optional ACC_SAT_EN: saturating adds with a per-group oSat flag.
module accumulator_64b_reg_hs
  import mac_pkg::*;
#(
  parameter int unsigned LEN       = ACC_LEN_DEFAULT,
  parameter int unsigned IBITWIDTH = PROD_BITWIDTH,
  parameter int unsigned OBITWIDTH = ACC_BITWIDTH
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic                 iValid,
  input  logic [IBITWIDTH-1:0] iData,
  output logic                 oReady,
  output logic                 oValid,
  output logic [OBITWIDTH-1:0] oData,
  input  logic                 iReady,
  output logic                 oSat
);

  localparam int unsigned CW = cnt_bits(LEN);

  logic [OBITWIDTH-1:0] r_acc;
  logic [OBITWIDTH-1:0] r_data;
  logic [CW-1:0]        r_cnt;
  logic                 r_valid;
  logic [OBITWIDTH-1:0] w_sum;
  logic                 w_sat;
  logic                 w_ready;
  acc_op_e              w_op;

  assign w_ready = iEn & ~iClr & (~r_valid | iReady);
  assign oReady  = w_ready;
  assign oValid  = r_valid;
  assign oData   = r_data;

  accumulator_sat_add #(
    .IBITWIDTH (IBITWIDTH),
    .OBITWIDTH (OBITWIDTH)
  ) u_add (
    .iA   (r_acc),
    .iB   (iData),
    .oSum (w_sum),
    .oSat (w_sat)
  );

  always_comb begin
    w_op = ACC_IDLE;
    if (iValid & w_ready)
      w_op = (r_cnt == CW'(LEN - 1)) ? ACC_DONE : ACC_ADD;
  end

  // A completion always wins over a drain, so a same-cycle drain+load keeps oValid high.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (iClr) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (w_op)
        ACC_ADD: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
          if (r_valid & iReady) r_valid <= 1'b0;
        end
        ACC_DONE: begin
          r_data  <= w_sum;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        default: begin
          if (r_valid & iReady) r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACC_SAT_EN
  logic r_grp_sat;
  logic r_sat;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_grp_sat <= 1'b0;
      r_sat     <= 1'b0;
    end else if (iClr) begin
      r_grp_sat <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      case (w_op)
        ACC_ADD:  r_grp_sat <= r_grp_sat | w_sat;
        ACC_DONE: begin
          r_sat     <= r_grp_sat | w_sat;
          r_grp_sat <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign oSat = r_sat;
`else
  // The wrap-mode adder drives its sat flag to constant 0.
  assign oSat = w_sat;
`endif

endmodule

// File: tb/tb_accumulator_64b_reg_hs.sv
// Directed bench for accumulator_64b_reg_hs: vector table, reset/saturation/LEN=1 sequences, random groups.
module tb_accumulator_64b_reg_hs;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: default configuration (LEN=4, 64 -> 72)
  logic        enA, clrA, vA, rdyA;
  logic [63:0] dA;
  logic        oRdyA, oVA, oSatA;
  logic [71:0] oDA;

  // DUT B: OBITWIDTH=64, LEN=2 for overflow behaviour
  logic        enB, clrB, vB, rdyB;
  logic [63:0] dB;
  logic        oRdyB, oVB, oSatB;
  logic [63:0] oDB;

  // DUT C: LEN=1
  logic        enC, clrC, vC, rdyC;
  logic [63:0] dC;
  logic        oRdyC, oVC, oSatC;
  logic [71:0] oDC;

  accumulator_64b_reg_hs #(.LEN(4), .IBITWIDTH(64), .OBITWIDTH(72)) dut_a (
    .iClk(clk), .iRst(rst), .iEn(enA), .iClr(clrA), .iValid(vA), .iData(dA),
    .oReady(oRdyA), .oValid(oVA), .oData(oDA), .iReady(rdyA), .oSat(oSatA));

  accumulator_64b_reg_hs #(.LEN(2), .IBITWIDTH(64), .OBITWIDTH(64)) dut_b (
    .iClk(clk), .iRst(rst), .iEn(enB), .iClr(clrB), .iValid(vB), .iData(dB),
    .oReady(oRdyB), .oValid(oVB), .oData(oDB), .iReady(rdyB), .oSat(oSatB));

  accumulator_64b_reg_hs #(.LEN(1), .IBITWIDTH(64), .OBITWIDTH(72)) dut_c (
    .iClk(clk), .iRst(rst), .iEn(enC), .iClr(clrC), .iValid(vC), .iData(dC),
    .oReady(oRdyC), .oValid(oVC), .oData(oDC), .iReady(rdyC), .oSat(oSatC));

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        rdy;
    logic        en;
    logic        clr;
    logic        er;
    logic        ev;
    logic [71:0] ed;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic rdy,
                              input logic en, input logic clr, input logic er,
                              input logic ev, input logic [71:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.en = en; r.clr = clr;
    r.er = er; r.ev = ev; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [63:0] d);
    vA = v; dA = d;
    @(posedge clk); #1;
  endtask

  localparam int G = 20;
  localparam int N = 4 * G;
  logic [63:0] prods[N];
  logic [71:0] exp_sum[G];
  logic [63:0] ones64;
  logic [63:0] exp_b;
  logic        exp_bsat;

  initial begin
    rst = 1'b1;
    enA = 1; clrA = 0; vA = 0; rdyA = 1; dA = '0;
    enB = 1; clrB = 0; vB = 0; rdyB = 1; dB = '0;
    enC = 1; clrC = 0; vC = 0; rdyC = 1; dC = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_valid", 72'(oVA), 72'(0));
    chk("reset_data", oDA, 72'(0));
    chk("reset_sat", 72'(oSatA), 72'(0));
    chk("reset_ready_en1", 72'(oRdyA), 72'(1));
    enA = 0; #1;
    chk("reset_ready_en0", 72'(oRdyA), 72'(0));
    enA = 1;
    @(posedge clk); #1;

    // v, d, rdy, en, clr, exp oReady (pre-edge), exp oValid, exp oData (post-edge)
    tbl.push_back(mk(1, 1,   1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 2,   1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3,   1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4,   1, 1, 0, 1, 1, 10));
    tbl.push_back(mk(1, 5,   0, 1, 0, 0, 1, 10));
    tbl.push_back(mk(1, 5,   0, 1, 0, 0, 1, 10));
    tbl.push_back(mk(1, 5,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 6,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 7,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 8,   1, 1, 0, 1, 1, 26));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 26));
    tbl.push_back(mk(1, 1,   1, 1, 0, 1, 0, 26));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 26));
    tbl.push_back(mk(1, 2,   1, 1, 0, 1, 0, 26));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 26));
    tbl.push_back(mk(1, 3,   1, 1, 0, 1, 0, 26));
    tbl.push_back(mk(1, 100, 1, 0, 0, 0, 0, 26));
    tbl.push_back(mk(1, 100, 1, 0, 0, 0, 0, 26));
    tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0, 26));
    tbl.push_back(mk(1, 4,   1, 1, 0, 1, 1, 10));
    tbl.push_back(mk(1, 100, 1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 200, 1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 999, 1, 1, 1, 0, 0, 10));
    tbl.push_back(mk(1, 1,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 1,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 1,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mk(1, 1,   1, 1, 0, 1, 1, 4));
    tbl.push_back(mk(0, 0,   0, 1, 1, 0, 0, 4));
    tbl.push_back(mk(1, 10,  1, 1, 0, 1, 0, 4));
    tbl.push_back(mk(1, 20,  1, 1, 0, 1, 0, 4));
    tbl.push_back(mk(1, 30,  1, 1, 0, 1, 0, 4));
    tbl.push_back(mk(1, 40,  1, 1, 0, 1, 1, 100));
    tbl.push_back(mk(0, 0,   1, 0, 0, 0, 0, 100));

    foreach (tbl[i]) begin
      vA = tbl[i].v; dA = tbl[i].d; rdyA = tbl[i].rdy;
      enA = tbl[i].en; clrA = tbl[i].clr;
      #1;
      chk($sformatf("tbl_ready[%0d]", i), 72'(oRdyA), 72'(tbl[i].er));
      @(posedge clk); #1;
      chk($sformatf("tbl_valid[%0d]", i), 72'(oVA), 72'(tbl[i].ev));
      chk($sformatf("tbl_data[%0d]", i), oDA, tbl[i].ed);
    end
    chk("tbl_sat", 72'(oSatA), 72'(0));

    // Asynchronous reset mid-group discards the partial sum
    enA = 1; clrA = 0; rdyA = 1;
    step_a(1, 100);
    step_a(1, 200);
    vA = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 72'(oVA), 72'(0));
    chk("rst_mid_data", oDA, 72'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    step_a(1, 1);
    step_a(1, 1);
    step_a(1, 1);
    chk("rst_mid_pre_valid", 72'(oVA), 72'(0));
    step_a(1, 1);
    chk("rst_mid_sum_valid", 72'(oVA), 72'(1));
    chk("rst_mid_sum_data", oDA, 72'(4));
    vA = 0;

    // OBITWIDTH=64: all-ones twice
    ones64 = '1;
`ifdef ACC_SAT_EN
    exp_b = ones64;
    exp_bsat = 1'b1;
`else
    exp_b = ones64 - 64'd1;
    exp_bsat = 1'b0;
`endif
    vB = 1; dB = ones64;
    @(posedge clk); #1;
    chk("ovf_first_valid", 72'(oVB), 72'(0));
    @(posedge clk); #1;
    chk("ovf_valid", 72'(oVB), 72'(1));
    chk("ovf_data", 72'(oDB), 72'(exp_b));
    chk("ovf_sat", 72'(oSatB), 72'(exp_bsat));
    dB = 64'd1;
    @(posedge clk); #1;
    dB = 64'd2;
    @(posedge clk); #1;
    vB = 0;
    chk("ovf_next_data", 72'(oDB), 72'(3));
    chk("ovf_next_sat", 72'(oSatB), 72'(0));

    // LEN=1: every accept completes, drain+load keeps oValid high
    vC = 1; dC = 64'd5;
    @(posedge clk); #1;
    chk("len1_v0", 72'(oVC), 72'(1));
    chk("len1_d0", oDC, 72'(5));
    dC = 64'd7;
    @(posedge clk); #1;
    chk("len1_v1", 72'(oVC), 72'(1));
    chk("len1_d1", oDC, 72'(7));
    dC = 64'd9;
    @(posedge clk); #1;
    chk("len1_d2", oDC, 72'(9));
    vC = 0;
    @(posedge clk); #1;
    chk("len1_drain", 72'(oVC), 72'(0));

    // Random products with random back-pressure
    for (int g = 0; g < G; g++) begin
      exp_sum[g] = '0;
      for (int k = 0; k < 4; k++) begin
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        prods[4*g+k] = 64'(a) * 64'(b);
        exp_sum[g] = exp_sum[g] + 72'(prods[4*g+k]);
      end
    end
    vA = 0; rdyA = 1;
    @(posedge clk); #1;
    begin
      int pi = 0;
      int go = 0;
      int cyc = 0;
      while (go < G && cyc < 3000) begin
        vA = (pi < N);
        dA = (pi < N) ? prods[pi] : '0;
        rdyA = 1'($urandom_range(0, 1));
        #1;
        if (oVA && rdyA) begin
          chk($sformatf("rand_sum[%0d]", go), oDA, exp_sum[go]);
          go++;
        end
        if (oRdyA && vA) pi++;
        @(posedge clk); #1;
        cyc++;
      end
      if (go != G) chk("rand_timeout", 72'(go), 72'(G));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
